// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the five-stage core: load-use stalls, MEM-stage branch flushes,
// data-memory wait states and halt. Optional perf counters under PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic [REG_W-1:0] if_id_rn,
  input  logic [REG_W-1:0] if_id_rm,
  input  logic             if_id_rm_used,
  input  logic             ex_mem_mem_access,
  input  logic             branch_taken,
  input  logic             halt_retire,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             pc_src,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  localparam logic [REG_W-1:0] XZR = '1;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       halt_now;
  logic       mem_stall;
  logic       load_use;
  logic       branch_act;
  logic       lu_act;

  always_comb begin
    halt_now   = (state == ST_HALT) || halt_retire;
    mem_stall  = ex_mem_mem_access && !dmem_ack;
    load_use   = id_ex_mem_read && (id_ex_rd != XZR) &&
                 ((id_ex_rd == if_id_rn) || (if_id_rm_used && (id_ex_rd == if_id_rm)));
    branch_act = branch_taken && !mem_stall;
    lu_act     = load_use && !mem_stall && !branch_taken;
  end

  // Outputs are gated by reset directly so an access in flight is dropped the moment
  // reset asserts, not at the next edge.
  always_comb begin
    // NOTE: every output gets a default before the branches; otherwise an uncovered path infers a latch.
    dmem_req     = 1'b0;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    pc_src       = 1'b0;
    halted       = reset && halt_now;
    if (reset && !halt_now) begin
      dmem_req  = ex_mem_mem_access;
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (mem_stall) begin
        // Older stages hold; MEM_WB keeps draining with bubbles.
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_flush = 1'b1;
      end else if (branch_act) begin
        pc_src       = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (lu_act) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (state != ST_HALT) begin
      if (halt_retire)    state_nxt = ST_HALT;
      else if (mem_stall) state_nxt = ST_MEM_WAIT;
      else                state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= ST_RUN;
    else        state <= state_nxt;
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!halt_now) begin
      if (mem_stall || lu_act) stall_cnt <= stall_cnt + 1'b1;
      if (branch_act)          flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a rule-level model.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rd, if_id_rn, if_id_rm;
  logic        if_id_rm_used, ex_mem_mem_access, branch_taken, halt_retire, dmem_ack;
  logic        dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_src, halted;
  logic [31:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .if_id_rn(if_id_rn), .if_id_rm(if_id_rm), .if_id_rm_used(if_id_rm_used),
    .ex_mem_mem_access(ex_mem_mem_access), .branch_taken(branch_taken),
    .halt_retire(halt_retire), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .pc_src(pc_src),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  // {dmem_req, en pc/if_id/id_ex/ex_mem/mem_wb, flush if_id/id_ex/ex_mem/mem_wb, pc_src, halted}
  logic [11:0] outs;
  assign outs = {dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_src, halted};

  localparam logic [11:0] O_DEFAULT = 12'b0_11111_0000_0_0;
  localparam logic [11:0] O_LOADUSE = 12'b0_00111_0100_0_0;
  localparam logic [11:0] O_STALL   = 12'b1_00001_0001_0_0;
  localparam logic [11:0] O_ACK     = 12'b1_11111_0000_0_0;
  localparam logic [11:0] O_BRANCH  = 12'b0_11111_1110_1_0;
  localparam logic [11:0] O_ACK_BR  = 12'b1_11111_1110_1_0;
  localparam logic [11:0] O_HALT    = 12'b0_00000_0000_0_1;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Reference model: only "halted" and the two event counts are remembered between cycles.
  logic        m_halted = 1'b0;
  logic [31:0] m_stall  = '0;
  logic [31:0] m_flush  = '0;

  function automatic logic [11:0] model_outs();
    logic [4:0] en;
    logic [3:0] fl;
    logic       req, stall, hazard, psrc;
    if (!reset) return '0;
    if (m_halted || halt_retire) return O_HALT;
    req    = ex_mem_mem_access;
    stall  = req && !dmem_ack;
    hazard = id_ex_mem_read && id_ex_rd != 5'd31 &&
             (id_ex_rd == if_id_rn || (if_id_rm_used && id_ex_rd == if_id_rm));
    en = 5'b11111; fl = 4'b0000; psrc = 1'b0;
    if (stall) begin
      en = 5'b00001; fl = 4'b0001;
    end else if (branch_taken) begin
      psrc = 1'b1; fl = 4'b1110;
    end else if (hazard) begin
      en = 5'b00111; fl = 4'b0100;
    end
    return {req, en, fl, psrc, 1'b0};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_halted <= 1'b0;
      m_stall  <= '0;
      m_flush  <= '0;
    end else begin
      if (!m_halted && !halt_retire) begin
        // The output pattern already encodes which event won this cycle.
        if (model_outs() == O_STALL || model_outs() == O_LOADUSE) m_stall <= m_stall + 1;
        if (model_outs() == O_BRANCH || model_outs() == O_ACK_BR) m_flush <= m_flush + 1;
      end
      if (halt_retire) m_halted <= 1'b1;
    end
  end

  always @(negedge clock) begin
    check("model_outs", outs, model_outs());
    check("model_stall_cnt", stall_cnt, PERF ? m_stall : 32'd0);
    check("model_flush_cnt", flush_cnt, PERF ? m_flush : 32'd0);
  end

  task automatic step(input logic rd_ld, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic rm_used, input logic acc,
                      input logic br, input logic hr, input logic ack);
    @(posedge clock);
    #1;
    id_ex_mem_read    = rd_ld;
    id_ex_rd          = rd;
    if_id_rn          = rn;
    if_id_rm          = rm;
    if_id_rm_used     = rm_used;
    ex_mem_mem_access = acc;
    branch_taken      = br;
    halt_retire       = hr;
    dmem_ack          = ack;
    @(negedge clock);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_pulse();
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    id_ex_mem_read = 1'b0; id_ex_rd = '0; if_id_rn = 5'd1; if_id_rm = 5'd2;
    if_id_rm_used = 1'b0; ex_mem_mem_access = 1'b0; branch_taken = 1'b0;
    halt_retire = 1'b0; dmem_ack = 1'b0;
    #2;
    check("reset_outs", outs, 12'd0);
    check("reset_stall_cnt", stall_cnt, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("first_cycle_default", outs, O_DEFAULT);

    // Load-use on rn, then clear; then the same pattern against XZR.
    step(1'b1, 5'd3, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("load_use", outs, O_LOADUSE);
    idle();
    check("load_use_next_default", outs, O_DEFAULT);
    step(1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("load_use_xzr", outs, O_DEFAULT);
    step(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("load_use_rm", outs, O_LOADUSE);

    // Memory access acked three cycles late.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("mem_wait_stall", outs, O_STALL);
    end
    step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("mem_wait_ack", outs, O_ACK);
    idle();
    check("mem_wait_stall_cnt", stall_cnt, PERF ? 32'd5 : 32'd0);

    // Zero-wait access leaves the stall count alone.
    step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("zero_wait", outs, O_ACK);
    idle();
    check("zero_wait_stall_cnt", stall_cnt, PERF ? 32'd5 : 32'd0);

    // Branch beats a simultaneous load-use match.
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("branch_over_hazard", outs, O_BRANCH);
    idle();
    check("branch_flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);

    // Branch held behind a two-cycle memory stall.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      check("branch_during_stall", outs, O_STALL);
    end
    step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("branch_on_ack", outs, O_ACK_BR);
    idle();
    check("branch_stall_counts", {stall_cnt, flush_cnt},
          PERF ? {32'd7, 32'd2} : 64'd0);

    // Randomized traffic; occasional halts are cleared with a reset pulse.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), rd, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0));
      if (m_halted && $urandom_range(0, 3) == 0) reset_pulse();
    end
    reset_pulse();
    idle();
    check("post_random_default", outs, O_DEFAULT);

    // Halt taken during a memory wait, then held regardless of inputs.
    step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_halt_stall", outs, O_STALL);
    step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("halt_retire_cycle", outs, O_HALT);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      check("halt_held", outs, O_HALT);
    end
    check("halt_frozen_stall_cnt", stall_cnt, PERF ? 32'd1 : 32'd0);

    // Asynchronous reset mid-cycle while a request is pending.
    reset_pulse();
    step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stall_before_reset", outs, O_STALL);
    #1 reset = 1'b0;
    #1;
    check("async_reset_outs", outs, 12'd0);
    check("async_reset_cnt", {stall_cnt, flush_cnt}, 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    ex_mem_mem_access = 1'b0;
    @(negedge clock);
    check("after_release_default", outs, O_DEFAULT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the five-stage ARMv8 core. It drives the enable and flush inputs of the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers, and resolves three conditions: load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory accesses over a req/ack handshake. It also holds the core in a halted state after a halt retires.

## Interface
- REG_W, 5, register-index width; index 31 is XZR.
- CNT_W, 32, performance counter width.

- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_ex_mem_read  in  1  instruction in ID_EX is a load.
- id_ex_rd  in  REG_W  destination of the ID_EX instruction.
- if_id_rn  in  REG_W  first source of the IF_ID instruction.
- if_id_rm  in  REG_W  second source of the IF_ID instruction.
- if_id_rm_used  in  1  the IF_ID instruction reads rm.
- ex_mem_mem_access  in  1  instruction in EX_MEM is a load or store.
- branch_taken  in  1  branch in EX_MEM is taken.
- halt_retire  in  1  halt instruction is in MEM_WB.
- dmem_ack  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data-memory request.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  synchronous bubble insert. The bubble is taken only when the matching enable is 1.
- pc_src  out  1  select the branch target for the next PC.
- halted  out  1  core is halted.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. The state register is reset to RUN.
- All other outputs are combinational from the state and the current inputs.
- Priority, highest first: HALT, then memory, then branch, then load-use.

HALT
- Entered from RUN or MEM_WAIT when halt_retire=1. This takes precedence over all other events in that cycle.
- All enables and flushes are 0, dmem_req=0, halted=1.
- Exited only by reset.

Memory access
- dmem_req = ex_mem_mem_access in RUN and in MEM_WAIT.
- The request is held until dmem_ack. dmem_ack is a single-cycle pulse and is legal in the same cycle as the request rises (zero-wait).
- RUN with req=1 and ack=0 moves to MEM_WAIT.
- During stall (req=1, ack=0): PC, IF_ID, ID_EX and EX_MEM hold (enable 0). MEM_WB takes a bubble (mem_wb_en=1, mem_wb_flush=1).
- Cycle with ack=1: all enables are 1, MEM_WB captures the result, and the FSM returns to RUN.

Branch
- Applies when branch_taken=1 and the core is not stalled.
- Asserts pc_src=1 and all enables.
- Flushes the three younger instructions: if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
- If branch_taken and a memory stall occur together, the stall wins and the branch is acted on in the ack cycle.

Load-use
- Hazard condition: id_ex_mem_read=1, id_ex_rd≠31, and either id_ex_rd==if_id_rn or (if_id_rm_used=1 and id_ex_rd==if_id_rm).
- Response: pc_en=0, if_id_en=0, id_ex_flush=1. The remaining enables are 1.
- Lasts exactly one cycle, because the load advances to EX_MEM.
- Ignored while a taken branch is being acted on.

Default
- All enables 1, all flushes 0, pc_src=0.

## Timing
- While reset=0: state is RUN, all enables and flushes are 0, dmem_req=0, pc_src=0, halted=0, and the counters are 0.
- Reset asserted mid-access drops dmem_req immediately. The memory side must discard the pending access.
- First cycle after reset release: RUN, with default outputs.
- Hazard and branch responses take effect the same cycle: zero latency, single cycle.
- State changes take effect at the next rising edge.
- Stall length is N cycles for an ack arriving N cycles after the request. Zero-wait gives no stall.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined:
  - stall_cnt increments on every memory-stall or load-use cycle.
  - flush_cnt increments on every branch-flush cycle.
  - Both counters wrap at 2^CNT_W, freeze in HALT and clear on reset.
- Undefined: both ports remain but are tied to 0, with no counter flops.

## Test plan
- Load-use: id_ex_mem_read=1, id_ex_rd=3, if_id_rn=3 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; defaults next cycle. Repeat with id_ex_rd=31 -> no stall.
- Memory wait: ex_mem_mem_access=1, ack after 3 cycles -> dmem_req high 4 cycles; PC..EX_MEM enables 0 and mem_wb_flush=1 for 3 cycles; all enables 1 on the ack cycle; stall_cnt=3 with PERF_EN defined.
- Zero-wait: req and ack in the same cycle -> no MEM_WAIT, all enables 1, stall_cnt unchanged.
- Branch vs. hazard: branch_taken=1 together with a load-use match -> pc_src=1; if_id/id_ex/ex_mem flushes 1; pc_en=1; flush_cnt+1.
- Branch during stall: branch_taken=1 with ack 2 cycles late -> pc_src=0 while waiting; pc_src=1 plus flushes in the ack cycle.
- Halt and reset: halt_retire=1 during MEM_WAIT -> HALT, halted=1, dmem_req=0, all enables 0 indefinitely. reset=0 asynchronously mid-cycle -> outputs cleared immediately; RUN after release.
